// File: rtl/sram_frame_reader_pkg.sv
// Shared constants and state encoding for the SRAM frame reader.
package sram_frame_reader_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 4;

  localparam int DEFAULT_FRAME_WORDS     = 76800;
  localparam int DEFAULT_MAX_OUTSTANDING = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/word_unpacker.sv
// Two-deep word buffer (current + next) that serializes each 32-bit word into
// four bytes, low byte first, tagging the frame's first and last bytes.
module word_unpacker
  import sram_frame_reader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              buf_empty,
  output logic              last_accept
);

  logic [DATA_W-1:0] cur_word_q, cur_word_d;
  logic              cur_first_q, cur_first_d;
  logic              cur_last_q, cur_last_d;
  logic              cur_valid_q, cur_valid_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] nxt_word_q, nxt_word_d;
  logic              nxt_first_q, nxt_first_d;
  logic              nxt_last_q, nxt_last_d;
  logic              nxt_valid_q, nxt_valid_d;
  logic              accept;
  logic              cur_free;

  always_comb begin
    cur_word_d  = cur_word_q;
    cur_first_d = cur_first_q;
    cur_last_d  = cur_last_q;
    cur_valid_d = cur_valid_q;
    idx_d       = idx_q;
    nxt_word_d  = nxt_word_q;
    nxt_first_d = nxt_first_q;
    nxt_last_d  = nxt_last_q;
    nxt_valid_d = nxt_valid_q;

    accept      = cur_valid_q && out_ready;
    last_accept = accept && (idx_q == 2'd3);
    cur_free    = !cur_valid_q || last_accept;

    if (accept) idx_d = idx_q + 2'd1;
    if (last_accept) cur_valid_d = 1'b0;

    // The held word has priority; an incoming word bypasses straight to the
    // serializer only when nothing is waiting, which keeps the N+1 latency.
    if (cur_free && nxt_valid_q) begin
      cur_word_d  = nxt_word_q;
      cur_first_d = nxt_first_q;
      cur_last_d  = nxt_last_q;
      cur_valid_d = 1'b1;
      idx_d       = 2'd0;
      nxt_valid_d = 1'b0;
    end else if (cur_free && in_valid) begin
      cur_word_d  = in_data;
      cur_first_d = in_first;
      cur_last_d  = in_last;
      cur_valid_d = 1'b1;
      idx_d       = 2'd0;
    end

    if (in_valid && !(cur_free && !nxt_valid_q)) begin
      nxt_word_d  = in_data;
      nxt_first_d = in_first;
      nxt_last_d  = in_last;
      nxt_valid_d = 1'b1;
    end

    out_valid = cur_valid_q;
    out_data  = PIX_W'(cur_word_q >> {idx_q, 3'b000});
    out_sof   = cur_valid_q && cur_first_q && (idx_q == 2'd0);
    out_eof   = cur_valid_q && cur_last_q && (idx_q == 2'd3);
    buf_empty = !nxt_valid_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_word_q  <= '0;
      cur_first_q <= 1'b0;
      cur_last_q  <= 1'b0;
      cur_valid_q <= 1'b0;
      idx_q       <= 2'd0;
      nxt_word_q  <= '0;
      nxt_first_q <= 1'b0;
      nxt_last_q  <= 1'b0;
      nxt_valid_q <= 1'b0;
    end else begin
      cur_word_q  <= cur_word_d;
      cur_first_q <= cur_first_d;
      cur_last_q  <= cur_last_d;
      cur_valid_q <= cur_valid_d;
      idx_q       <= idx_d;
      nxt_word_q  <= nxt_word_d;
      nxt_first_q <= nxt_first_d;
      nxt_last_q  <= nxt_last_d;
      nxt_valid_q <= nxt_valid_d;
    end
  end

endmodule

// File: rtl/sram_frame_reader.sv
// Reads one frame of 32-bit words from the SRAM arbiter and streams it out as
// bytes, bounding the number of reads in flight.
module sram_frame_reader
  import sram_frame_reader_pkg::*;
#(
  parameter int FRAME_WORDS     = DEFAULT_FRAME_WORDS,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              busy,
  output logic              done,
  output logic              rd_addr_valid,
  input  logic              rd_addr_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_dout_ready,
  input  logic              rd_dout_valid,
  input  logic [DATA_W-1:0] rd_dout,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_eof
);

  localparam logic [ADDR_W-1:0] FRAME_LEN = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  MAX_OUT   = CNT_W'(MAX_OUTSTANDING);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              pop_pending_q, pop_pending_d;

  logic busy_int;
  logic addr_xfer;
  logic capture;
  logic eof_accept;
  logic buf_empty;
  logic last_accept;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    issued_d = issued_q;
    words_d  = words_q;
    outst_d  = outst_q;

    busy_int      = (state_q != IDLE);
    busy          = busy_int;
    rd_addr       = base_q + issued_q;
    rd_addr_valid = !reset && (state_q == ISSUE) &&
                    (issued_q < FRAME_LEN) && (outst_q < MAX_OUT);
    addr_xfer     = rd_addr_valid && rd_addr_ready;
    // Only one pop in flight, and only when the returned word has a slot.
    rd_dout_ready = !reset && busy_int && !pop_pending_q && (buf_empty || last_accept);
    pop_pending_d = rd_dout_ready;
    capture       = busy_int && pop_pending_q && rd_dout_valid;
    eof_accept    = pix_valid && pix_ready && pix_eof;
    done          = !reset && busy_int && eof_accept;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          base_d   = frame_base;
          issued_d = '0;
          words_d  = '0;
          outst_d  = '0;
        end
      end
      ISSUE: begin
        if (addr_xfer && (issued_q == LAST_WORD)) state_d = DRAIN;
      end
      default: ;
    endcase

    if (addr_xfer) issued_d = issued_q + 1'b1;
    if (capture) words_d = words_q + 1'b1;

    case ({addr_xfer, capture})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: ;
    endcase

    if (done) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      issued_q      <= '0;
      words_q       <= '0;
      outst_q       <= '0;
      pop_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issued_q      <= issued_d;
      words_q       <= words_d;
      outst_q       <= outst_d;
      pop_pending_q <= pop_pending_d;
    end
  end

  word_unpacker u_unpacker (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (capture),
    .in_data     (rd_dout),
    .in_first    (words_q == '0),
    .in_last     (words_q == LAST_WORD),
    .out_ready   (pix_ready),
    .out_valid   (pix_valid),
    .out_data    (pix_data),
    .out_sof     (pix_sof),
    .out_eof     (pix_eof),
    .buf_empty   (buf_empty),
    .last_accept (last_accept)
  );

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader with a behavioural arbiter read FIFO.
module tb_sram_frame_reader;

  localparam int FW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [17:0] frame_base = '0;
  logic        busy;
  logic        done;
  logic        rd_addr_valid;
  logic        rd_addr_ready = 1'b1;
  logic [17:0] rd_addr;
  logic        rd_dout_ready;
  logic        rd_dout_valid = 1'b0;
  logic [31:0] rd_dout = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [7:0]  pix_data;
  logic        pix_sof;
  logic        pix_eof;

  int tests = 0;
  int failures = 0;

  // Stimulus controls set by the main sequence
  logic        pix_mode = 1'b0;
  logic        addr_mode = 1'b0;
  logic        hold_data = 1'b0;
  logic        inject_valid = 1'b0;
  logic [31:0] data_xor = '0;
  logic        tog = 1'b0;

  // Arbiter model state
  logic [31:0] fifo[$];
  logic        resp_real = 1'b0;
  logic        pop_now;
  logic [31:0] pop_word;

  // Monitor state
  logic [17:0] addr_q[$];
  logic [9:0]  pix_q[$];
  int          done_cnt = 0;
  int          stall_bad = 0;
  int          astall_bad = 0;
  int          busy_bad = 0;
  int          done_bad = 0;
  int          idle_pix = 0;
  int          cyc = 0;
  int          first_resp_cyc = 0;
  int          first_pix_cyc = 0;
  int          last_pix_cyc = 0;
  logic        have_resp = 1'b0;
  logic        have_pix = 1'b0;
  logic        prev_pstall = 1'b0;
  logic        prev_astall = 1'b0;
  logic        prev_done = 1'b0;
  logic [7:0]  s_data;
  logic        s_sof;
  logic        s_eof;
  logic [17:0] s_addr;

  logic [17:0] wrap_exp [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};

  sram_frame_reader #(
    .FRAME_WORDS     (FW),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .frame_base    (frame_base),
    .busy          (busy),
    .done          (done),
    .rd_addr_valid (rd_addr_valid),
    .rd_addr_ready (rd_addr_ready),
    .rd_addr       (rd_addr),
    .rd_dout_ready (rd_dout_ready),
    .rd_dout_valid (rd_dout_valid),
    .rd_dout       (rd_dout),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_eof       (pix_eof)
  );

  always #5 clock = ~clock;

  // Ready patterns change on the falling edge, away from the DUT's sampling edge
  initial forever begin
    @(negedge clock);
    tog = !tog;
    pix_ready = pix_mode ? tog : 1'b1;
    rd_addr_ready = addr_mode ? !tog : 1'b1;
  end

  // Arbiter: accepted addresses queue data; a pop returns the head one cycle later
  initial forever begin
    @(posedge clock);
    pop_now = !reset && rd_dout_ready && !hold_data && (fifo.size() > 0);
    pop_word = 32'hBAD0_0BAD;
    if (pop_now) pop_word = fifo.pop_front();
    if (reset) fifo.delete();
    else if (rd_addr_valid && rd_addr_ready) fifo.push_back({14'd0, rd_addr} ^ data_xor);
    #1;
    rd_dout_valid = pop_now || inject_valid;
    rd_dout = pop_word;
    resp_real = pop_now;
  end

  // Monitor: records transfers and pixels, flags protocol violations
  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset || (start && !busy)) begin
      addr_q.delete();
      pix_q.delete();
      done_cnt = 0;
      have_resp = 1'b0;
      have_pix = 1'b0;
    end
    if (reset) begin
      prev_pstall = 1'b0;
      prev_astall = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_pstall && !(pix_valid && pix_data == s_data && pix_sof == s_sof && pix_eof == s_eof))
        stall_bad++;
      if (prev_astall && !(rd_addr_valid && rd_addr == s_addr)) astall_bad++;
      if (prev_done && busy) busy_bad++;
      if (pix_valid && !busy) idle_pix++;
      if (done) begin
        done_cnt++;
        if (!(pix_valid && pix_ready && pix_eof)) done_bad++;
      end
      if (resp_real && !have_resp) begin
        have_resp = 1'b1;
        first_resp_cyc = cyc;
      end
      if (pix_valid && pix_ready) begin
        pix_q.push_back({pix_eof, pix_sof, pix_data});
        if (!have_pix) begin
          have_pix = 1'b1;
          first_pix_cyc = cyc;
        end
        last_pix_cyc = cyc;
      end
      if (rd_addr_valid && rd_addr_ready) addr_q.push_back(rd_addr);
      prev_pstall = pix_valid && !pix_ready;
      s_data = pix_data;
      s_sof = pix_sof;
      s_eof = pix_eof;
      prev_astall = rd_addr_valid && !rd_addr_ready;
      s_addr = rd_addr;
      prev_done = done;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one cycle with the given base address
  task automatic applyStimulus(input logic [17:0] base);
    frame_base = base;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("done_within_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic checkFrame(input logic [17:0] base);
    logic [17:0] a;
    logic [31:0] w;
    logic [9:0]  e;
    checkOutput("addr_count", addr_q.size(), FW);
    for (int k = 0; k < FW; k++) begin
      a = base + 18'(k);
      if (k < addr_q.size()) checkOutput("addr_seq", {14'd0, addr_q[k]}, {14'd0, a});
    end
    checkOutput("pixel_count", pix_q.size(), 4 * FW);
    for (int i = 0; i < 4 * FW; i++) begin
      a = base + 18'(i / 4);
      w = {14'd0, a} ^ data_xor;
      e = {i == 4 * FW - 1, i == 0, 8'(w >> (8 * (i % 4)))};
      if (i < pix_q.size()) checkOutput("pixel_eof_sof_data", {22'd0, pix_q[i]}, {22'd0, e});
    end
    checkOutput("done_pulses", done_cnt, 1);
  endtask

  task automatic checkIdleOutputs(input string phase);
    checkOutput({phase, "_busy"}, 32'(busy), 0);
    checkOutput({phase, "_done"}, 32'(done), 0);
    checkOutput({phase, "_rd_addr_valid"}, 32'(rd_addr_valid), 0);
    checkOutput({phase, "_rd_dout_ready"}, 32'(rd_dout_ready), 0);
    checkOutput({phase, "_pix_valid"}, 32'(pix_valid), 0);
    checkOutput({phase, "_pix_sof"}, 32'(pix_sof), 0);
    checkOutput({phase, "_pix_eof"}, 32'(pix_eof), 0);
    checkOutput({phase, "_rd_addr"}, {14'd0, rd_addr}, 0);
    checkOutput({phase, "_pix_data"}, {24'd0, pix_data}, 0);
  endtask

  initial begin
    int n;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Basic frame, data equals address, everything ready
    applyStimulus(18'h00010);
    waitDone(200);
    checkFrame(18'h00010);
    checkOutput("first_pixel_latency", first_pix_cyc - first_resp_cyc, 1);
    checkOutput("no_pixel_bubbles", last_pix_cyc - first_pix_cyc, 4 * FW - 1);
    @(negedge clock);
    checkOutput("busy_after_done", 32'(busy), 0);

    // Backpressure on both the pixel and the address side
    data_xor = 32'hC35A_9600;
    pix_mode = 1'b1;
    addr_mode = 1'b1;
    applyStimulus(18'h2A5C3);
    waitDone(400);
    checkFrame(18'h2A5C3);
    checkOutput("pixel_stable_while_stalled", stall_bad, 0);
    checkOutput("addr_stable_while_stalled", astall_bad, 0);
    pix_mode = 1'b0;
    addr_mode = 1'b0;
    @(negedge clock);

    // Address wrap at the top of the 18-bit space
    data_xor = 32'h1234_0000;
    applyStimulus(18'h3FFFE);
    waitDone(200);
    checkFrame(18'h3FFFE);
    for (int k = 0; k < 4; k++)
      if (k < addr_q.size()) checkOutput("wrap_addr", {14'd0, addr_q[k]}, {14'd0, wrap_exp[k]});

    // Unsolicited read data while idle, then withheld data caps reads in flight
    inject_valid = 1'b1;
    repeat (4) @(negedge clock);
    inject_valid = 1'b0;
    @(negedge clock);
    checkOutput("unsolicited_no_pixel", idle_pix, 0);
    checkOutput("unsolicited_pix_valid_low", 32'(pix_valid), 0);
    data_xor = 32'hE1D2_0000;
    hold_data = 1'b1;
    applyStimulus(18'h01000);
    repeat (20) @(negedge clock);
    checkOutput("withheld_addr_count", addr_q.size(), 2);
    checkOutput("withheld_addr_valid_low", 32'(rd_addr_valid), 0);
    checkOutput("withheld_no_pixels", pix_q.size(), 0);
    hold_data = 1'b0;
    waitDone(300);
    checkFrame(18'h01000);

    // Second start while busy is ignored, then reset lands mid-drain
    data_xor = 32'h00AA_0000;
    applyStimulus(18'h20000);
    @(negedge clock);
    applyStimulus(18'h30000);
    n = 0;
    while (addr_q.size() < FW && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("all_issued_before_reset", 32'(n < 100), 32'd1);
    repeat (2) @(negedge clock);
    checkOutput("busy_mid_frame", 32'(busy), 1);
    checkOutput("frame_incomplete_before_reset", 32'(pix_q.size() < 4 * FW), 1);
    for (int k = 0; k < FW; k++)
      if (k < addr_q.size()) checkOutput("restart_ignored_addr", {14'd0, addr_q[k]}, 32'h20000 + k);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkIdleOutputs("midframe_reset");
    @(negedge clock);
    data_xor = 32'h7700_0000;
    applyStimulus(18'h00100);
    waitDone(200);
    checkFrame(18'h00100);

    checkOutput("busy_falls_after_done", busy_bad, 0);
    checkOutput("done_coincides_with_eof", done_bad, 0);
    checkOutput("no_pixel_while_idle", idle_pix, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
